// File: rtl/mult_share_arbiter.sv
// Round-robin front end that shares one sequential multiplier among NREQ requesters:
// captures the winner's operands, starts the core, waits (with timeout) and returns the product.
module mult_share_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]      rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    output logic                    locked,
    input  logic                    mul_done,
    input  logic [2*WIDTH-1:0]      mul_p
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SW = IW + 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [SW-1:0] NREQ_S   = SW'(NREQ);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state, state_nxt;
    logic [IW-1:0]      ptr, ptr_nxt;
    logic [IW-1:0]      win, win_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [NREQ-1:0]    grant_nxt;
    logic [NREQ-1:0]    rsp_valid_nxt;
    logic [PW-1:0]      rsp_data_nxt;
    logic               rsp_err_nxt;
    logic               busy_nxt;
    logic               mul_start_nxt;
    logic [WIDTH-1:0]   mul_a_nxt;
    logic [WIDTH-1:0]   mul_b_nxt;
    logic               locked_nxt;

    // Per-requester operand views
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    // Rotate requests so ptr sits at bit 0, find the lowest set bit, then rotate back
    logic [2*NREQ-1:0]  req_dbl;
    logic [NREQ-1:0]    req_rot;
    logic [IW-1:0]      rot_off;
    logic [SW-1:0]      pick_sum;
    logic [IW-1:0]      pick;
    logic [NREQ-1:0]    pick_oh;
    logic [NREQ-1:0]    win_oh;
    logic [SW-1:0]      inc_sum;
    logic [IW-1:0]      ptr_inc;

    assign req_dbl = {req, req};
    assign req_rot = NREQ'(req_dbl >> ptr);

    always_comb begin
        rot_off = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_off = IW'(i);
            end
        end
    end

    assign pick_sum = {1'b0, ptr} + {1'b0, rot_off};
    assign pick     = (pick_sum >= NREQ_S) ? IW'(pick_sum - NREQ_S) : IW'(pick_sum);
    assign pick_oh  = NREQ'(1) << pick;
    assign win_oh   = NREQ'(1) << win;
    assign inc_sum  = {1'b0, win} + SW'(1);
    assign ptr_inc  = (inc_sum >= NREQ_S) ? '0 : IW'(inc_sum);

    // Next-state and next-output logic; pulses default low, data holds
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        win_nxt       = win;
        cnt_nxt       = cnt;
        grant_nxt     = '0;
        rsp_valid_nxt = '0;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = rsp_err;
        busy_nxt      = 1'b0;
        mul_start_nxt = 1'b0;
        mul_a_nxt     = mul_a;
        mul_b_nxt     = mul_b;
        locked_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                if (|req) begin
                    state_nxt     = S_ISSUE;
                    win_nxt       = pick;
                    mul_a_nxt     = a_arr[pick];
                    mul_b_nxt     = b_arr[pick];
                    grant_nxt     = pick_oh;
                    mul_start_nxt = 1'b1;
                    locked_nxt    = 1'b1;
                    busy_nxt      = 1'b1;
                end
            end
            S_ISSUE: begin
                state_nxt  = S_WAIT;
                cnt_nxt    = '0;
                locked_nxt = 1'b1;
                busy_nxt   = 1'b1;
            end
            S_WAIT: begin
                busy_nxt = 1'b1;
                // Completion takes priority over a coincident timeout
                if (mul_done) begin
                    state_nxt     = S_RESP;
                    rsp_data_nxt  = mul_p;
                    rsp_err_nxt   = 1'b0;
                    rsp_valid_nxt = win_oh;
                end else if (cnt == CNT_LAST) begin
                    state_nxt     = S_RESP;
                    rsp_data_nxt  = '0;
                    rsp_err_nxt   = 1'b1;
                    rsp_valid_nxt = win_oh;
                end else begin
                    cnt_nxt    = cnt + CW'(1);
                    locked_nxt = 1'b1;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
                ptr_nxt   = ptr_inc;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            win       <= '0;
            cnt       <= '0;
            grant     <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            win       <= win_nxt;
            cnt       <= cnt_nxt;
            grant     <= grant_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_err   <= rsp_err_nxt;
            busy      <= busy_nxt;
            mul_start <= mul_start_nxt;
            mul_a     <= mul_a_nxt;
            mul_b     <= mul_b_nxt;
            locked    <= locked_nxt;
        end
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sequential 8x8 shift-add multiplier among NREQ requesters.
- Picks a requester and latches its operands. Drives the multiplier's start pulse and holds operands stable ("locked") while it runs.
- Waits for the multiplier's done, then returns the 16-bit product to the winning requester.
- Sits between client logic (keypad/operand sources, display driver) and the existing multiplier core.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width; product is 2*WIDTH.
- TIMEOUT, 64, max cycles in WAIT before the transaction is aborted with an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NREQ  per-requester request level.
- req_a  in  NREQ*WIDTH  operand A per requester; slice i = bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B per requester, same packing.
- grant  out  NREQ  one-hot, 1-cycle pulse: operands of that requester captured.
- rsp_valid  out  NREQ  one-hot, 1-cycle pulse: result for that requester on rsp_data/rsp_err.
- rsp_data  out  2*WIDTH  product.
- rsp_err  out  1  high with rsp_valid on timeout.
- busy  out  1  high in every state except IDLE.
- mul_start  out  1  1-cycle start pulse to multiplier.
- mul_a  out  WIDTH  latched operand A to multiplier.
- mul_b  out  WIDTH  latched operand B to multiplier.
- locked  out  1  high from mul_start until done or timeout; operands must not change.
- mul_done  in  1  multiplier completion (level or pulse; first high cycle in WAIT used).
- mul_p  in  2*WIDTH  multiplier product, valid while mul_done high.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - state=IDLE, ptr=0.
  - grant, rsp_valid, rsp_err, mul_start, locked, busy = 0.
  - rsp_data, mul_a, mul_b = 0. Timeout counter = 0.
  - rst overrides everything, including mid-transaction. Any in-flight result is dropped and no rsp_valid is issued.
- All outputs are registered.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If req != 0 at an edge, select the first set bit scanning from ptr upward, wrapping at NREQ-1 -> 0.
  - Latch req_a/req_b of the winner into mul_a/mul_b and record the winner index.
  - Next state ISSUE.
- ISSUE (1 cycle): grant[winner]=1, mul_start=1, locked=1, busy=1. Next state WAIT.
- WAIT: locked=1, mul_start=0, timeout counter increments each cycle.
  - If mul_done=1 at an edge: rsp_data<=mul_p, rsp_err<=0, go RESP.
  - Else if counter reaches TIMEOUT-1: rsp_data<=0, rsp_err<=1, go RESP.
  - If mul_done and timeout coincide, done wins.
- RESP (1 cycle): rsp_valid[winner]=1, locked=0. Then ptr<=(winner+1) mod NREQ, counter cleared, next state IDLE.
- rsp_data/rsp_err hold their value until the next RESP.
- Requester protocol:
  - Hold req and operands stable until grant[i] is seen.
  - req still high after rsp_valid is a new request.
  - Dropping req before grant withdraws the request, no error.
- mul_done outside WAIT is ignored.
- Latency: req seen in IDLE at edge E; grant/mul_start in cycle E+1. With mul_done first high in cycle D, rsp_valid is in cycle D+1. Minimum one IDLE cycle between transactions.
- Fairness: a continuously requesting index waits at most NREQ-1 transactions.
- Operand/width: no arithmetic in the block. mul_p is passed through unmodified, full 2*WIDTH bits.

Test Plan:
- Single request: req=0001, a0=129, b0=19, multiplier done 8 cycles after start, mul_p=2451 -> grant=0001 one cycle, mul_start one cycle, rsp_valid=0001 with rsp_data=2451, rsp_err=0, locked low afterwards.
- Max operands: req=0100, a2=255, b2=255 -> rsp_data=65025 (0xFE01) to rsp_valid=0100.
- Round-robin: req=1111 held for 5 transactions after reset -> grant order 0,1,2,3,0. With req=1010 and ptr=2 -> grant order 3,1.
- Timeout: mul_done tied 0, TIMEOUT=64 -> rsp_valid pulse 64 cycles after WAIT entry, rsp_err=1, rsp_data=0, then next request is served normally.
- Reset mid-operation: assert rst during WAIT -> next cycle all outputs 0 and state IDLE. No rsp_valid ever issued for the aborted request. ptr=0.
- Stray/coincident done: mul_done pulsed in IDLE -> no response. mul_done on the same edge as timeout expiry -> rsp_err=0, rsp_data=mul_p.
